// File: rtl/scic_timer_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, bit positions, widths.
package scic_timer_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PRESCALE_W = 16;
  localparam int unsigned CTRL_W     = 3;

  // Word offsets from BASE_ADDR
  localparam logic [ADDR_W-1:0] OFF_CTRL     = 16'd0;
  localparam logic [ADDR_W-1:0] OFF_PRESCALE = 16'd1;
  localparam logic [ADDR_W-1:0] OFF_COUNT    = 16'd2;
  localparam logic [ADDR_W-1:0] OFF_COMPARE  = 16'd3;
  localparam logic [ADDR_W-1:0] OFF_STATUS   = 16'd4;
  localparam logic [ADDR_W-1:0] NUM_REGS     = 16'd5;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT      = 2;

  // STATUS bit positions
  localparam int unsigned STATUS_MATCH_BIT = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: counts 0..limit while enabled, ticks on the wrap cycle.
module timer_prescaler
  import scic_timer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  wrap_c;

  // >= keeps the counter bounded even if the limit were ever lowered under it
  assign wrap_c = (cnt_q >= limit);
  // A clear restarts the period, so it suppresses any tick in the same cycle
  assign tick_c = en & ~clr & ~reset & wrap_c;

  // Next count: clear wins, otherwise advance/wrap while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap_c ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 32-bit timer with prescaler, compare/match status and level irq.
// Build option: define IO_TIMER_IRQ_EN to enable the CTRL.IRQ_EN bit and the irq output;
// without it IRQ_EN reads 0 and irq is held low while MATCH still works.
module io_timer
  import scic_timer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFFF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_out,
  output logic              irq
);

`ifdef IO_TIMER_IRQ_EN
  localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b111;
`else
  localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b011;
`endif

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [DATA_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]     compare_q, compare_d;
  logic                  match_q, match_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  irq_q, irq_d;

  logic [ADDR_W-1:0] offset_c;
  logic              in_range_c;
  logic              wr_ctrl_c, wr_prescale_c, wr_count_c, wr_compare_c, wr_status_c;
  logic              pre_clr_c;
  logic              tick_c;
  logic              hit_c;

  // Address decode relative to the block base
  assign offset_c      = ADDR_W'(address - BASE_ADDR);
  assign in_range_c    = (offset_c < NUM_REGS);
  assign wr_ctrl_c     = we & in_range_c & (offset_c == OFF_CTRL);
  assign wr_prescale_c = we & in_range_c & (offset_c == OFF_PRESCALE);
  assign wr_count_c    = we & in_range_c & (offset_c == OFF_COUNT);
  assign wr_compare_c  = we & in_range_c & (offset_c == OFF_COMPARE);
  assign wr_status_c   = we & in_range_c & (offset_c == OFF_STATUS);

  // Restart the prescale period on a PRESCALE write or when the timer is disabled
  assign pre_clr_c = wr_prescale_c | (wr_ctrl_c & ~data_in[CTRL_EN_BIT]);
  assign hit_c     = (count_q == compare_q);

  timer_prescaler u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .en     (ctrl_q[CTRL_EN_BIT]),
    .clr    (pre_clr_c),
    .limit  (prescale_q),
    .tick_c (tick_c)
  );

  // Register updates, counting, match tracking and read mux
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;
    data_out_d = '0;
    irq_d      = 1'b0;

    if (wr_ctrl_c)     ctrl_d     = data_in[CTRL_W-1:0] & CTRL_WR_MASK;
    if (wr_prescale_c) prescale_d = data_in[PRESCALE_W-1:0];
    if (wr_compare_c)  compare_d  = data_in;

    // A CPU write to COUNT overrides the tick update in the same cycle
    if (tick_c) begin
      count_d = (hit_c & ctrl_q[CTRL_AUTO_RELOAD_BIT]) ? '0 : count_q + DATA_W'(1);
    end
    if (wr_count_c) count_d = data_in;

    // A new match outranks a coincident write-1-to-clear
    if (wr_status_c & data_in[STATUS_MATCH_BIT]) match_d = 1'b0;
    if (tick_c & hit_c)                          match_d = 1'b1;

`ifdef IO_TIMER_IRQ_EN
    irq_d = match_q & ctrl_q[CTRL_IRQ_EN_BIT];
`endif

    if (in_range_c) begin
      unique case (offset_c)
        OFF_CTRL:     data_out_d = DATA_W'(ctrl_q);
        OFF_PRESCALE: data_out_d = DATA_W'(prescale_q);
        OFF_COUNT:    data_out_d = count_q;
        OFF_COMPARE:  data_out_d = compare_q;
        OFF_STATUS:   data_out_d = DATA_W'(match_q);
        default:      data_out_d = '0;
      endcase
    end
  end

  // State registers; reset outranks any simultaneous write or tick
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: read expectations queued at issue, compared when data_out lands.
module tb_io_timer;

  localparam logic [15:0] BASE       = 16'hFFF0;
  localparam logic [15:0] A_CTRL     = BASE + 16'd0;
  localparam logic [15:0] A_PRESCALE = BASE + 16'd1;
  localparam logic [15:0] A_COUNT    = BASE + 16'd2;
  localparam logic [15:0] A_COMPARE  = BASE + 16'd3;
  localparam logic [15:0] A_STATUS   = BASE + 16'd4;
  localparam logic [15:0] A_IDLE     = 16'h0000;

`ifdef IO_TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [15:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        irq;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    we      = 1'b1;
    step();
    we      = 1'b0;
    address = A_IDLE;
  endtask

  // Issue a read: the expectation is queued now and retired once data_out is registered
  task automatic rd(input logic [15:0] a, input string tag, input logic [31:0] exp);
    address = a;
    we      = 1'b0;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    step();
    address = A_IDLE;
    check(tag_q.pop_front(), data_out, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    we      = 1'b0;
    address = A_IDLE;
    data_in = '0;
    step();
    step();
    check("rst_data_out", data_out, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;

    // Reset values and out-of-range reads
    rd(A_COUNT,  "rst_count", 32'h0);
    rd(16'h0100, "rd_out_of_range", 32'h0);
    rd(A_CTRL,   "rst_ctrl", 32'h0);
    rd(A_STATUS, "rst_status", 32'h0);

    // Register write/readback, unused bits, ignored out-of-range writes
    wr(A_COMPARE,  32'hDEAD_BEEF);
    wr(A_PRESCALE, 32'h1234_ABCD);
    wr(A_CTRL,     32'hFFFF_FFFF);
    rd(A_CTRL, "ctrl_readback", IRQ_ON ? 32'h7 : 32'h3);
    wr(A_CTRL, 32'h0);
    wr(BASE + 16'd5, 32'h1111_1111);
    wr(BASE - 16'd1, 32'h2222_2222);
    rd(A_COMPARE,    "compare_readback", 32'hDEAD_BEEF);
    rd(A_PRESCALE,   "prescale_readback", 32'h0000_ABCD);
    rd(BASE + 16'd5, "rd_base_plus5", 32'h0);

    // Prescale 3, compare 5, auto-reload: sixth tick (edge 24 after enable) matches
    wr(A_PRESCALE, 32'd3);
    wr(A_COMPARE,  32'd5);
    wr(A_COUNT,    32'd0);
    wr(A_STATUS,   32'd1);
    wr(A_CTRL,     32'h3);
    for (int i = 0; i < 22; i++) step();
    rd(A_STATUS, "pre_match_status", 32'h0);
    rd(A_COUNT,  "count_at_sixth_tick", 32'd5);
    rd(A_STATUS, "match_set", 32'h1);
    rd(A_COUNT,  "count_reloaded", 32'd0);
    check("irq_disabled", 32'(irq), 32'h0);
    wr(A_CTRL,   32'h0);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, "status_w1c", 32'h0);

    // Prescale 0: 0xFFFF_FFFF wraps to 0 without a match
    wr(A_PRESCALE, 32'd0);
    wr(A_COMPARE,  32'd7);
    wr(A_COUNT,    32'hFFFF_FFFF);
    wr(A_CTRL,     32'h1);
    rd(A_COUNT,  "count_before_wrap", 32'hFFFF_FFFF);
    rd(A_COUNT,  "count_wrapped", 32'h0);
    rd(A_STATUS, "no_match_on_wrap", 32'h0);
    wr(A_CTRL, 32'h0);

    // COUNT write coincident with a tick: written value wins
    wr(A_COUNT, 32'd50);
    wr(A_CTRL,  32'h1);
    wr(A_COUNT, 32'd100);
    rd(A_COUNT, "count_write_wins", 32'd100);
    rd(A_COUNT, "count_after_write", 32'd101);
    wr(A_CTRL, 32'h0);

    // irq path: set, survive a coincident clear+match, then drop after a clean clear
    wr(A_COMPARE, 32'd3);
    wr(A_COUNT,   32'd0);
    wr(A_STATUS,  32'd1);
    wr(A_CTRL,    32'h5);
    for (int i = 0; i < 4; i++) step();
    check("irq_not_yet", 32'(irq), 32'h0);
    step();
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    wr(A_COUNT,  32'd3);
    wr(A_STATUS, 32'd1);
    check("irq_hold_coincident", 32'(irq), 32'(IRQ_ON));
    rd(A_STATUS, "match_survives_clear", 32'h1);
    check("irq_still_set", 32'(irq), 32'(IRQ_ON));
    wr(A_STATUS, 32'd1);
    check("irq_lags_clear", 32'(irq), 32'(IRQ_ON));
    step();
    check("irq_cleared", 32'(irq), 32'h0);
    rd(A_STATUS, "status_cleared", 32'h0);
    wr(A_CTRL, 32'h0);

    // Reset mid-count with a pending match and a coincident CTRL write
    wr(A_PRESCALE, 32'd0);
    wr(A_COMPARE,  32'd50);
    wr(A_COUNT,    32'd49);
    wr(A_STATUS,   32'd1);
    wr(A_CTRL,     32'h1);
    step();
    reset   = 1'b1;
    we      = 1'b1;
    address = A_CTRL;
    data_in = 32'h7;
    step();
    reset   = 1'b0;
    we      = 1'b0;
    address = A_IDLE;
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    rd(A_CTRL,     "midrst_ctrl", 32'h0);
    rd(A_PRESCALE, "midrst_prescale", 32'h0);
    rd(A_COUNT,    "midrst_count", 32'h0);
    rd(A_COMPARE,  "midrst_compare", 32'h0);
    rd(A_STATUS,   "midrst_status", 32'h0);
    step();
    step();
    rd(A_COUNT, "count_frozen_after_rst", 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFFF0: word address of the first register; the block decodes BASE_ADDR+0 to BASE_ADDR+4.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  16  CPU word address.
REQ-005 data_in  input  32  CPU write data.
REQ-006 we  input  1  write strobe, one cycle per write.
REQ-007 data_out  output  32  read data to CPU.
REQ-008 irq  output  1  level interrupt request.

Function
REQ-009 Register map, offsets from BASE_ADDR:
- 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
- 1 PRESCALE: bits 15:0.
- 2 COUNT: 32 bits.
- 3 COMPARE: 32 bits.
- 4 STATUS: bit0 MATCH, write-1-to-clear.
- Unused bits read 0.
REQ-010 Register write on the rising edge where we=1 and address is in range; out-of-range writes are ignored.
REQ-011 Read latency is one cycle: data_out is registered from the address presented in the previous cycle.
REQ-012 data_out is 0 when the previous-cycle address was out of range, so the system can OR it with memory read data.
REQ-013 With EN=1, the prescale counter counts 0..PRESCALE and then wraps; a tick occurs on the wrap cycle. PRESCALE=0 gives a tick every cycle.
REQ-014 On a tick, COUNT increments modulo 2^32.
REQ-015 On a tick where COUNT==COMPARE:
- MATCH is set.
- If AUTO_RELOAD=1, COUNT loads 0 instead of incrementing.
REQ-016 EN=0 freezes both the prescale counter and COUNT.
REQ-017 Writing CTRL with EN=0 also clears the prescale counter.
REQ-018 Simultaneous CPU write to COUNT and a tick: the written value wins and no increment occurs that cycle.
REQ-019 Writing PRESCALE clears the prescale counter.
REQ-020 Simultaneous STATUS write-1-to-clear and a new match: MATCH remains set.
REQ-021 irq = MATCH & IRQ_EN, registered, asserted one cycle after MATCH sets.

Reset
REQ-022 reset=1 on a rising edge sets CTRL, PRESCALE, COUNT, COMPARE, STATUS, the prescale counter, data_out and irq to 0.
REQ-023 Reset mid-count aborts the count; no tick or match is generated in the reset cycle.
REQ-024 Reset has priority over a simultaneous write.

Configuration
REQ-025 Macro IO_TIMER_IRQ_EN.
- Defined: IRQ_EN bit and irq output behave per REQ-021.
- Undefined: IRQ_EN reads 0, irq is tied to 0, and MATCH/STATUS still function.

Structure
REQ-026 Shared package scic_timer_pkg holds:
- Register offset constants (CTRL=0 to STATUS=4).
- CTRL/STATUS bit-position constants.
- Register width constants.
REQ-027 One sub-module, timer_prescaler: 16-bit counter with clear/enable inputs and a tick output. All other logic is in io_timer.

Verification
REQ-028 Reset, then read BASE_ADDR+2 -> data_out=0 one cycle later; read 16'h0100 -> data_out=0.
REQ-029 PRESCALE=3, COMPARE=5, CTRL=3'b011 -> tick every 4 cycles; MATCH sets on the 6th tick; COUNT then reads 0.
REQ-030 PRESCALE=0, COUNT=32'hFFFF_FFFF, COMPARE=7, CTRL=1 -> COUNT wraps to 0 next cycle; MATCH stays 0.
REQ-031 Write COUNT=100 in the same cycle as a tick -> COUNT reads 100, not 101.
REQ-032 With IO_TIMER_IRQ_EN defined, CTRL=3'b101, match occurs -> irq=1 one cycle later. Write STATUS=1 coincident with another match -> irq stays 1. Later clear with no match -> irq=0 next cycle.
REQ-033 Assert reset while COUNT=50 and EN=1 -> all registers read 0; no match is generated.
